// File: rtl/keccak_out_writer.sv
// keccak_out_writer: streams keccak words into memory from a command address.
// Define KECCAK_OUT_WRITER_SKID_EN for a 2-entry FIFO ahead of memory.
module keccak_out_writer #(
  parameter int AddrSize  = 12,
  parameter int CountSize = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AddrSize+CountSize-1:0] cmd,
  input  logic                          cmd_isReady,
  output logic                          cmd_canReceive,
  input  logic [63:0]                   in,
  input  logic                          in_isReady,
  output logic                          in_canReceive,
  input  logic                          in_isLast_in,
  output logic                          in_isLast_out,
  output logic [AddrSize-1:0]           mem_addr,
  output logic [63:0]                   mem_data,
  output logic                          mem_wr,
  input  logic                          mem_canWrite,
  output logic                          done
);

  typedef enum logic [1:0] {
    Idle,
    Run,
    Drain
  } state_t;

  state_t               state;
  logic [AddrSize-1:0]  addr;
  logic [CountSize-1:0] remaining;
  logic                 doneQ;

  logic                 cmdAccept;
  logic                 xfer;
  logic                 lastXfer;
  logic                 wrDone;
  logic                 drained;
  logic [AddrSize-1:0]  cmdAddr;
  logic [CountSize-1:0] cmdCount;

  assign cmdAddr  = cmd[AddrSize+CountSize-1:CountSize];
  assign cmdCount = cmd[CountSize-1:0];

  // rst gates the ready so nothing is offered while reset is held
  assign cmd_canReceive = rst & (state == Idle);
  assign cmdAccept      = cmd_canReceive & cmd_isReady;
  assign xfer           = in_canReceive & in_isReady;
  assign lastXfer       = xfer &
                          ((remaining == CountSize'(1)) | in_isLast_in);
  assign in_isLast_out  = lastXfer;
  assign wrDone         = mem_wr & mem_canWrite;
  assign mem_addr       = addr;
  assign done           = doneQ;

`ifdef KECCAK_OUT_WRITER_SKID_EN
  logic [63:0] fifoMem [2];
  logic        wrPtr;
  logic        rdPtr;
  logic [1:0]  fifoCnt;

  assign in_canReceive = (state == Run) & (fifoCnt != 2'd2);
  assign mem_wr        = (fifoCnt != 2'd0);
  assign mem_data      = fifoMem[rdPtr];
  assign drained       = (fifoCnt == 2'd0);

  always_ff @(posedge clk) begin
    if (xfer) fifoMem[wrPtr] <= in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr   <= 1'b0;
      rdPtr   <= 1'b0;
      fifoCnt <= 2'd0;
    end else begin
      if (xfer)   wrPtr <= ~wrPtr;
      if (wrDone) rdPtr <= ~rdPtr;
      fifoCnt <= fifoCnt + {1'b0, xfer} - {1'b0, wrDone};
    end
  end
`else
  assign in_canReceive = (state == Run) & mem_canWrite;
  assign mem_wr        = (state == Run) & in_isReady;
  assign mem_data      = in;
  assign drained       = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= Idle;
      addr      <= '0;
      remaining <= '0;
      doneQ     <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (wrDone) addr <= addr + AddrSize'(1);
      unique case (state)
        Idle: begin
          if (cmdAccept) begin
            addr      <= cmdAddr;
            remaining <= cmdCount;
            if (cmdCount == '0) doneQ <= 1'b1;
            else                state <= Run;
          end
        end
        Run: begin
          if (lastXfer) begin
            remaining <= '0;
            state     <= Drain;
          end else if (xfer) begin
            remaining <= remaining - CountSize'(1);
          end
        end
        Drain: begin
          if (drained) begin
            state <= Idle;
            doneQ <= 1'b1;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_out_writer.sv
// tb_keccak_out_writer: scoreboard bench for keccak_out_writer.
// Expected {addr,data} pushed on transfer, popped on completed write.
module tb_keccak_out_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] cmd = '0;
  logic        cmd_isReady = 1'b0;
  logic        cmd_canReceive;
  logic [63:0] in = '0;
  logic        in_isReady = 1'b0;
  logic        in_canReceive;
  logic        in_isLast_in = 1'b0;
  logic        in_isLast_out;
  logic [11:0] mem_addr;
  logic [63:0] mem_data;
  logic        mem_wr;
  logic        mem_canWrite = 1'b1;
  logic        done;

  keccak_out_writer #(.AddrSize(12), .CountSize(12)) dut (
    .clk(clk), .rst(rst),
    .cmd(cmd), .cmd_isReady(cmd_isReady),
    .cmd_canReceive(cmd_canReceive),
    .in(in), .in_isReady(in_isReady),
    .in_canReceive(in_canReceive),
    .in_isLast_in(in_isLast_in),
    .in_isLast_out(in_isLast_out),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wr(mem_wr), .mem_canWrite(mem_canWrite),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] a;
    logic [63:0] d;
  } wr_t;

  wr_t         sb[$];
  int          nVec = 0;
  int          nErr = 0;
  int          xferCnt = 0;
  int          expN = 0;
  int          doneCnt = 0;
  int          wrCnt = 0;
  int          cyc = 0;
  int          lastAt = -1;
  int          mode = 0;
  logic [11:0] base = '0;
  logic [11:0] curN = '0;
  logic [3:0]  pat = 4'b1001;
  bit          active = 0;
  bit          pendAct = 0;
  bit          monOn = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // producer: new random stimulus each cycle
  always @(posedge clk) begin
    #1;
    cyc++;
    mem_canWrite = (mode == 1) ? pat[cyc % 4] : 1'b1;
    in_isReady   = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    in           = {$urandom, $urandom};
    in_isLast_in = (xferCnt == lastAt);
  end

  always @(negedge clk) begin
    wr_t w;
    if (monOn) begin
      if (done) doneCnt++;
      if (pendAct) begin
        active  = 1;
        pendAct = 0;
      end
      if (cmd_canReceive && cmd_isReady && curN != 0) pendAct = 1;
      if (active) begin
`ifdef KECCAK_OUT_WRITER_SKID_EN
        check("inRdy", 64'(in_canReceive), 64'(sb.size() < 2));
`else
        check("inRdy", 64'(in_canReceive), 64'(mem_canWrite));
`endif
      end else begin
        check("holdOff", 64'(in_canReceive), 64'd0);
      end
      if (in_isReady && in_canReceive) begin
        check("isLast", 64'(in_isLast_out), 64'(xferCnt == expN - 1));
        w.a = base + 12'(xferCnt);
        w.d = in;
        sb.push_back(w);
        xferCnt++;
        if (xferCnt >= expN) active = 0;
      end else if (in_isLast_out) begin
        check("isLastIdle", 64'(in_isLast_out), 64'd0);
      end
      if (mem_wr && mem_canWrite) begin
        if (sb.size() == 0) begin
          check("spuriousWr", 64'd1, 64'd0);
        end else begin
          w = sb.pop_front();
          check("addr", 64'(mem_addr), 64'(w.a));
          check("data", mem_data, w.d);
          wrCnt++;
        end
      end
    end
  end

  task automatic runCmd(logic [11:0] b, logic [11:0] n,
                        int la, int m, int ab);
    int t;
    base    = b;
    curN    = n;
    lastAt  = la;
    mode    = m;
    expN    = (la >= 0 && la < int'(n)) ? la + 1 : int'(n);
    xferCnt = 0;
    wrCnt   = 0;
    doneCnt = 0;
    @(posedge clk);
    #2;
    cmd         = {b, n};
    cmd_isReady = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_canReceive && t < 50);
    check("cmdAcc", 64'(cmd_canReceive), 64'd1);
    @(posedge clk);
    #2 cmd_isReady = 1'b0;
    if (n == 0) begin
      @(negedge clk);
      check("zeroDone", 64'(done), 64'd1);
    end
    if (ab > 0) begin
      t = 0;
      while (xferCnt < ab && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("abortReach", 64'(xferCnt >= ab), 64'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      monOn = 0;
      check("rstWr", 64'(mem_wr), 64'd0);
      check("rstInRdy", 64'(in_canReceive), 64'd0);
      check("rstCmdRdy", 64'(cmd_canReceive), 64'd0);
      check("rstDone", 64'(done), 64'd0);
      @(posedge clk);
      #2 rst = 1'b1;
      sb.delete();
      active  = 0;
      pendAct = 0;
      doneCnt = 0;
      lastAt  = -1;
      expN    = 0;
      monOn   = 1;
      repeat (6) @(negedge clk);
      check("noDoneAbort", 64'(doneCnt), 64'd0);
      check("cmdRdyAfter", 64'(cmd_canReceive), 64'd1);
      return;
    end
    t = 0;
    while (doneCnt == 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("doneSeen", 64'(doneCnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    check("doneOnce", 64'(doneCnt), 64'd1);
    check("xfers", 64'(xferCnt), 64'(expN));
    check("writes", 64'(wrCnt), 64'(expN));
    check("sbEmpty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #12;
    check("rstCmdRdy0", 64'(cmd_canReceive), 64'd0);
    check("rstInRdy0", 64'(in_canReceive), 64'd0);
    check("rstLast0", 64'(in_isLast_out), 64'd0);
    check("rstWr0", 64'(mem_wr), 64'd0);
    check("rstDone0", 64'(done), 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("firstCmdRdy", 64'(cmd_canReceive), 64'd1);
    monOn = 1;
    runCmd(12'h010, 12'd4, -1, 0, 0);
    runCmd(12'hFFE, 12'd3, -1, 0, 0);
    runCmd(12'h100, 12'd0, -1, 0, 0);
    runCmd(12'h020, 12'd8, 2, 0, 0);
    runCmd(12'h000, 12'd16, -1, 1, 0);
    runCmd(12'h040, 12'd10, -1, 0, 5);
    runCmd(12'h300, 12'd5, -1, 1, 0);
    runCmd(12'hFFD, 12'd6, 4, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/keccak_out_writer.md
KECCAK_OUT_WRITER -- requirements
Module: keccak_out_writer

Interface
REQ-001 Parameter AddrSize, default 12: memory word-address width.
REQ-002 Parameter CountSize, default 12: word-count width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cmd  input  AddrSize+CountSize  {baseAddr:AddrSize, numWords:CountSize}.
REQ-006 cmd_isReady  input  1  cmd valid.
REQ-007 cmd_canReceive  output  1  cmd accepted this cycle when both high.
REQ-008 in  input  64  sampled keccak word (4 x 16-bit coefficients).
REQ-009 in_isReady  input  1  in valid.
REQ-010 in_canReceive  output  1  word transferred when in_isReady & in_canReceive.
REQ-011 in_isLast_in  input  1  producer end-of-stream marker, sampled only on a transfer.
REQ-012 in_isLast_out  output  1  high in the transfer cycle of the command's final word.
REQ-013 mem_addr  output  AddrSize  write address.
REQ-014 mem_data  output  64  write data.
REQ-015 mem_wr  output  1  write request.
REQ-016 mem_canWrite  input  1  write completes when mem_wr & mem_canWrite.
REQ-017 done  output  1  one-cycle pulse when a command has completed.

Function
REQ-018 States IDLE, RUN, DRAIN; IDLE -> RUN on cmd accept with numWords != 0.
REQ-019 cmd_canReceive SHALL be high only in IDLE.
REQ-020 Accepted numWords == 0: no transfers, stay IDLE, done pulses the following cycle.
REQ-021 On cmd accept: addr <= baseAddr, remaining <= numWords.
REQ-022 Each transfer decrements remaining; each completed write increments addr modulo 2^AddrSize (wrap from all-ones to 0 allowed, no flag).
REQ-023 in_isLast_out = in_canReceive & in_isReady & (remaining == 1 | in_isLast_in), combinational.
REQ-024 in_canReceive SHALL be low in IDLE and DRAIN and never exceed numWords transfers per command.
REQ-025 Transfer with in_isLast_in = 1 ends the command early after that word; remaining discarded.
REQ-026 After the final transfer: RUN -> DRAIN until every accepted word is written, then IDLE with done pulse.
REQ-027 Write order SHALL equal transfer order; no word dropped or duplicated under any mem_canWrite pattern.
REQ-028 in_isReady with no command active SHALL be held off (in_canReceive = 0), never consumed.

Reset
REQ-029 rst low: state IDLE, addr 0, remaining 0, buffers empty; cmd_canReceive, in_canReceive, in_isLast_out, mem_wr, done all 0 while asserted.
REQ-030 rst asserted mid-command: command and buffered words abandoned, no further mem_wr, no done.
REQ-031 First cycle after rst release: cmd_canReceive = 1.

Configuration
REQ-032 Macro KECCAK_OUT_WRITER_SKID_EN selects the datapath.
REQ-033 Undefined: pass-through; mem_wr = RUN & in_isReady, mem_data = in, in_canReceive = RUN & mem_canWrite; zero latency, DRAIN lasts one cycle.
REQ-034 Defined: 2-entry FIFO between in and memory; in_canReceive = RUN & FIFO not full, independent of mem_canWrite; mem_wr = FIFO not empty; in-to-mem_wr latency 1 cycle; simultaneous push and pop on full FIFO not permitted, on non-full allowed.

Verification
REQ-035 cmd {0x010, 4}, in_isReady always, mem_canWrite always -> writes to 0x010..0x013 in order, in_isLast_out on 4th transfer, one done pulse.
REQ-036 cmd {0xFFE, 3} -> writes to 0xFFE, 0xFFF, 0x000.
REQ-037 cmd {0x100, 0} -> no mem_wr, done one cycle after accept, next cmd accepted.
REQ-038 cmd {0x020, 8}, in_isLast_in on 3rd transfer -> exactly 3 writes (0x020..0x022), in_isLast_out on 3rd, done after drain.
REQ-039 cmd {0x000, 16}, mem_canWrite toggling 1-0-0-1 pattern, random in_isReady -> 16 writes, data order preserved; with SKID_EN in_canReceive stays high while FIFO not full.
REQ-040 rst low for 1 cycle after 5 of 10 words -> mem_wr 0 immediately, no done, new cmd accepted after release.
